// File: rtl/arm_cond_pkg.sv
// Shared types for the Execute-stage condition unit.
// Optional build macro: ARM_COND_PERF_CNT_EN (executed/skipped counters).
package arm_cond_pkg;

    // ARM condition-field encoding
    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_HS = 4'h2, COND_LO = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
    } condition_t;

    // Architectural flags, packed as {N,Z,C,V}
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    // Bit positions of each flag within a {N,Z,C,V} vector
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/arm_cond_if.sv
// Execute-stage control bus between the hazard/decode side and the condition unit.
// master drives the Execute-stage controls, slave is the condition unit.
interface arm_cond_if #(
    parameter int unsigned CNT_W = 32
);
    logic             i_Stall;
    logic             i_Flush;
    logic             i_Valid_E;
    logic [3:0]       i_Cond_E;
    logic [1:0]       i_FlagWrite_E;
    logic [3:0]       i_ALUFlags_E;
    logic             i_PCSrc_E;
    logic             i_RegWrite_E;
    logic             i_MemWrite_E;
    logic             o_CondEx_E;
    logic             o_PCSrc_E;
    logic             o_PCSrc_M;
    logic             o_RegWrite_M;
    logic             o_MemWrite_M;
    logic [3:0]       o_Flags;
    logic [CNT_W-1:0] o_ExecCnt;
    logic [CNT_W-1:0] o_SkipCnt;

    modport master (
        output i_Stall, i_Flush, i_Valid_E, i_Cond_E, i_FlagWrite_E,
               i_ALUFlags_E, i_PCSrc_E, i_RegWrite_E, i_MemWrite_E,
        input  o_CondEx_E, o_PCSrc_E, o_PCSrc_M, o_RegWrite_M,
               o_MemWrite_M, o_Flags, o_ExecCnt, o_SkipCnt
    );

    modport slave (
        input  i_Stall, i_Flush, i_Valid_E, i_Cond_E, i_FlagWrite_E,
               i_ALUFlags_E, i_PCSrc_E, i_RegWrite_E, i_MemWrite_E,
        output o_CondEx_E, o_PCSrc_E, o_PCSrc_M, o_RegWrite_M,
               o_MemWrite_M, o_Flags, o_ExecCnt, o_SkipCnt
    );
endinterface

// File: rtl/arm_cond_eval.sv
// Pure combinational evaluation of an ARM condition field against {N,Z,C,V}.
module arm_cond_eval
    import arm_cond_pkg::*;
(
    input  condition_t cond_i,
    input  flags_t     flags_i,
    output logic       pass_o
);

    // Condition truth table
    always_comb begin
        pass_o = 1'b0;
        case (cond_i)
            COND_EQ: pass_o = flags_i.z;
            COND_NE: pass_o = !flags_i.z;
            COND_HS: pass_o = flags_i.c;
            COND_LO: pass_o = !flags_i.c;
            COND_MI: pass_o = flags_i.n;
            COND_PL: pass_o = !flags_i.n;
            COND_VS: pass_o = flags_i.v;
            COND_VC: pass_o = !flags_i.v;
            COND_HI: pass_o = flags_i.c && !flags_i.z;
            COND_LS: pass_o = !flags_i.c || flags_i.z;
            COND_GE: pass_o = (flags_i.n == flags_i.v);
            COND_LT: pass_o = (flags_i.n != flags_i.v);
            COND_GT: pass_o = !flags_i.z && (flags_i.n == flags_i.v);
            COND_LE: pass_o = flags_i.z || (flags_i.n != flags_i.v);
            COND_AL: pass_o = 1'b1;
            COND_NV: pass_o = 1'b0;
            default: pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/arm_cond_unit.sv
// Execute-stage conditional-logic controller: owns NZCV, gates the write
// enables of the Execute instruction and registers them into Memory.
// Optional build macro: ARM_COND_PERF_CNT_EN adds saturating counters of
// executed/skipped conditional (non-AL) instructions.
module arm_cond_unit
    import arm_cond_pkg::*;
#(
    parameter int unsigned CNT_W     = 32,
    parameter logic [3:0]  FLAGS_RST = 4'h0
) (
    input  logic          i_CLK,
    input  logic          i_RST,
    arm_cond_if.slave     bus
);

    flags_t flags_q;
    flags_t flags_d;
    logic   pcsrc_m_q;
    logic   regwrite_m_q;
    logic   memwrite_m_q;
    logic   cond_pass;
    logic   live;
    logic   cond_ex;

    arm_cond_eval u_eval (
        .cond_i  (condition_t'(bus.i_Cond_E)),
        .flags_i (flags_q),
        .pass_o  (cond_pass)
    );

    // Qualify the condition with instruction liveness
    always_comb begin
        live    = bus.i_Valid_E && !bus.i_Flush;
        cond_ex = live && cond_pass;
    end

    // Next flags: each half updated only by an executed flag-setter
    always_comb begin
        flags_d = flags_q;
        if (cond_ex && bus.i_FlagWrite_E[1]) begin
            flags_d.n = bus.i_ALUFlags_E[FLAG_N];
            flags_d.z = bus.i_ALUFlags_E[FLAG_Z];
        end
        if (cond_ex && bus.i_FlagWrite_E[0]) begin
            flags_d.c = bus.i_ALUFlags_E[FLAG_C];
            flags_d.v = bus.i_ALUFlags_E[FLAG_V];
        end
    end

    // Flags and Memory-stage register; stall holds everything, reset wins
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            flags_q      <= flags_t'(FLAGS_RST);
            pcsrc_m_q    <= 1'b0;
            regwrite_m_q <= 1'b0;
            memwrite_m_q <= 1'b0;
        end else if (!bus.i_Stall) begin
            flags_q      <= flags_d;
            pcsrc_m_q    <= cond_ex && bus.i_PCSrc_E;
            regwrite_m_q <= cond_ex && bus.i_RegWrite_E;
            memwrite_m_q <= cond_ex && bus.i_MemWrite_E;
        end
    end

    assign bus.o_CondEx_E   = cond_ex;
    assign bus.o_PCSrc_E    = cond_ex && bus.i_PCSrc_E;
    assign bus.o_PCSrc_M    = pcsrc_m_q;
    assign bus.o_RegWrite_M = regwrite_m_q;
    assign bus.o_MemWrite_M = memwrite_m_q;
    assign bus.o_Flags      = flags_q;

`ifdef ARM_COND_PERF_CNT_EN
    logic [CNT_W-1:0] exec_cnt_q;
    logic [CNT_W-1:0] skip_cnt_q;
    logic             counted;

    assign counted = live && (condition_t'(bus.i_Cond_E) != COND_AL);

    // Saturating executed/skipped counters for conditional instructions
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            exec_cnt_q <= '0;
            skip_cnt_q <= '0;
        end else if (!bus.i_Stall && counted) begin
            if (cond_pass && (exec_cnt_q != {CNT_W{1'b1}}))
                exec_cnt_q <= exec_cnt_q + CNT_W'(1);
            if (!cond_pass && (skip_cnt_q != {CNT_W{1'b1}}))
                skip_cnt_q <= skip_cnt_q + CNT_W'(1);
        end
    end

    assign bus.o_ExecCnt = exec_cnt_q;
    assign bus.o_SkipCnt = skip_cnt_q;
`else
    assign bus.o_ExecCnt = {CNT_W{1'b0}};
    assign bus.o_SkipCnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_arm_cond_unit.sv
// Self-checking bench for arm_cond_unit: condition table, directed corner
// sequences and a randomized run against a behavioural model.
module tb_arm_cond_unit;

    localparam int unsigned CNT_W   = 2;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;

    // Behavioural model state
    logic [3:0] m_flags;
    bit         m_pc_m, m_rw_m, m_mw_m;
    int         m_exec, m_skip;

    arm_cond_if #(.CNT_W(CNT_W)) bus ();

    arm_cond_unit #(.CNT_W(CNT_W), .FLAGS_RST(4'h0)) dut (
        .i_CLK (clk),
        .i_RST (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Conditions come in complementary pairs; AL/NV are constants
    function automatic bit m_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v, base;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        if (c == 4'hE) return 1'b1;
        if (c == 4'hF) return 1'b0;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cf;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cf && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b0;
        endcase
        return base ^ c[0];
    endfunction

    task automatic drive(input bit valid, input logic [3:0] cond, input logic [1:0] fw,
                         input logic [3:0] alu, input bit pc, input bit rw, input bit mw,
                         input bit stall, input bit flush);
        bus.i_Valid_E     = valid;
        bus.i_Cond_E      = cond;
        bus.i_FlagWrite_E = fw;
        bus.i_ALUFlags_E  = alu;
        bus.i_PCSrc_E     = pc;
        bus.i_RegWrite_E  = rw;
        bus.i_MemWrite_E  = mw;
        bus.i_Stall       = stall;
        bus.i_Flush       = flush;
    endtask

    task automatic model_reset();
        m_flags = 4'h0;
        m_pc_m = 0; m_rw_m = 0; m_mw_m = 0;
        m_exec = 0; m_skip = 0;
    endtask

    task automatic check_regs();
        chk("flags", 32'(bus.o_Flags), 32'(m_flags));
        chk("pcsrc_m", 32'(bus.o_PCSrc_M), 32'(m_pc_m));
        chk("regwrite_m", 32'(bus.o_RegWrite_M), 32'(m_rw_m));
        chk("memwrite_m", 32'(bus.o_MemWrite_M), 32'(m_mw_m));
`ifdef ARM_COND_PERF_CNT_EN
        chk("exec_cnt", 32'(bus.o_ExecCnt), 32'(m_exec));
        chk("skip_cnt", 32'(bus.o_SkipCnt), 32'(m_skip));
`else
        chk("exec_cnt", 32'(bus.o_ExecCnt), 32'd0);
        chk("skip_cnt", 32'(bus.o_SkipCnt), 32'd0);
`endif
    endtask

    // One clock: check combinational outputs, clock, advance model, check registers
    task automatic cyc();
        bit live, pass, ce;
        #1;
        live = bus.i_Valid_E && !bus.i_Flush;
        pass = m_pass(bus.i_Cond_E, m_flags);
        ce   = live && pass;
        chk("condex_e", 32'(bus.o_CondEx_E), 32'(ce));
        chk("pcsrc_e", 32'(bus.o_PCSrc_E), 32'(ce && bus.i_PCSrc_E));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (!bus.i_Stall) begin
            if (ce && bus.i_FlagWrite_E[1]) m_flags[3:2] = bus.i_ALUFlags_E[3:2];
            if (ce && bus.i_FlagWrite_E[0]) m_flags[1:0] = bus.i_ALUFlags_E[1:0];
            m_pc_m = ce && bus.i_PCSrc_E;
            m_rw_m = ce && bus.i_RegWrite_E;
            m_mw_m = ce && bus.i_MemWrite_E;
            if (live && bus.i_Cond_E != 4'hE) begin
                if (pass) m_exec = (m_exec == CNT_MAX) ? m_exec : m_exec + 1;
                else      m_skip = (m_skip == CNT_MAX) ? m_skip : m_skip + 1;
            end
        end
        #1;
        check_regs();
    endtask

    typedef struct {
        logic [3:0] flags;
        logic [3:0] cond;
        bit         exp;
    } vec_t;

    vec_t tbl[14];

    initial begin
        n_vec = 0;
        n_bad = 0;
        model_reset();

        // Condition table with hand-derived expectations
        tbl[0]  = '{4'b0100, 4'h0, 1'b1};   // EQ, Z=1
        tbl[1]  = '{4'b0000, 4'h0, 1'b0};   // EQ, Z=0
        tbl[2]  = '{4'b1000, 4'hA, 1'b0};   // GE, N!=V
        tbl[3]  = '{4'b1000, 4'hB, 1'b1};   // LT, N!=V
        tbl[4]  = '{4'b0010, 4'h8, 1'b1};   // HI, C=1 Z=0
        tbl[5]  = '{4'b0110, 4'h8, 1'b0};   // HI, Z=1
        tbl[6]  = '{4'b0110, 4'h9, 1'b1};   // LS, Z=1
        tbl[7]  = '{4'b1001, 4'hA, 1'b1};   // GE, N==V
        tbl[8]  = '{4'b0000, 4'hC, 1'b1};   // GT
        tbl[9]  = '{4'b0100, 4'hD, 1'b1};   // LE, Z=1
        tbl[10] = '{4'b0000, 4'hF, 1'b0};   // NV
        tbl[11] = '{4'b0000, 4'hE, 1'b1};   // AL
        tbl[12] = '{4'b0001, 4'h6, 1'b1};   // VS
        tbl[13] = '{4'b0010, 4'h3, 1'b0};   // LO, C=1

        // Reset then idle
        drive(0, 4'h0, 2'b00, 4'h0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_regs();
        rst = 1'b0;
        cyc();
        chk("rst_flags", 32'(bus.o_Flags), 32'h0);
        drive(1, 4'h0, 2'b00, 4'h0, 0, 0, 0, 0, 0);   // EQ with Z=0
        #1 chk("eq_after_rst", 32'(bus.o_CondEx_E), 32'd0);
        bus.i_Cond_E = 4'h1;                           // NE
        #1 chk("ne_after_rst", 32'(bus.o_CondEx_E), 32'd1);
        drive(0, 4'h0, 2'b00, 4'h0, 0, 0, 0, 0, 0);
        cyc();

        // Table loop: load flags with an AL setter, then test the condition
        for (int i = 0; i < 14; i++) begin
            drive(1, 4'hE, 2'b11, tbl[i].flags, 0, 0, 0, 0, 0);
            cyc();
            drive(1, tbl[i].cond, 2'b00, 4'h0, 0, 1, 0, 0, 0);
            #1 chk($sformatf("tbl%0d", i), 32'(bus.o_CondEx_E), 32'(tbl[i].exp));
            cyc();
        end

        // Back-to-back: setter then EQ+RegWrite sees new Z
        rst = 1'b1; drive(0, 4'h0, 2'b00, 4'h0, 0, 0, 0, 0, 0); cyc(); rst = 1'b0;
        drive(1, 4'hE, 2'b11, 4'b0100, 0, 0, 0, 0, 0); cyc();
        chk("b2b_flags", 32'(bus.o_Flags), 32'h4);
        drive(1, 4'h0, 2'b00, 4'h0, 0, 1, 0, 0, 0); cyc();
        chk("b2b_regwrite_m", 32'(bus.o_RegWrite_M), 32'd1);

        // Failed GE with FlagWrite must not touch flags; LT passes
        drive(1, 4'hE, 2'b11, 4'b1000, 0, 0, 0, 0, 0); cyc();
        drive(1, 4'hA, 2'b11, 4'b0111, 0, 0, 1, 0, 0); cyc();
        chk("ge_memwrite_m", 32'(bus.o_MemWrite_M), 32'd0);
        chk("ge_flags_hold", 32'(bus.o_Flags), 32'h8);
        drive(1, 4'hB, 2'b00, 4'h0, 0, 0, 1, 0, 0); cyc();
        chk("lt_memwrite_m", 32'(bus.o_MemWrite_M), 32'd1);

        // Independent C,V half update
        rst = 1'b1; drive(0, 4'h0, 2'b00, 4'h0, 0, 0, 0, 0, 0); cyc(); rst = 1'b0;
        drive(1, 4'hE, 2'b01, 4'b1111, 0, 0, 0, 0, 0); cyc();
        chk("cv_only", 32'(bus.o_Flags), 32'h3);

        // Stall+flush holds, then flush alone bubbles
        drive(1, 4'hE, 2'b11, 4'b0100, 1, 1, 1, 0, 0); cyc();
        drive(1, 4'h0, 2'b11, 4'b0000, 1, 1, 1, 1, 1); cyc();
        chk("stall_pc_m", 32'(bus.o_PCSrc_M), 32'd1);
        chk("stall_flags", 32'(bus.o_Flags), 32'h4);
        drive(1, 4'h0, 2'b11, 4'b0000, 1, 1, 1, 0, 1); cyc();
        chk("flush_pc_m", 32'(bus.o_PCSrc_M), 32'd0);
        chk("flush_flags", 32'(bus.o_Flags), 32'h4);

        // Reset during stall wins
        drive(1, 4'hE, 2'b11, 4'b1111, 1, 1, 1, 1, 0); rst = 1'b1; cyc(); rst = 1'b0;
        chk("rst_in_stall", 32'(bus.o_Flags), 32'h0);

`ifdef ARM_COND_PERF_CNT_EN
        // Counter saturation: AL setters uncounted, 5 passing EQ saturate at 3
        drive(1, 4'hE, 2'b11, 4'b0100, 0, 0, 0, 0, 0); cyc();
        for (int i = 0; i < 5; i++) begin
            drive(1, 4'h0, 2'b00, 4'h0, 0, 1, 0, 0, 0); cyc();
        end
        chk("exec_sat", 32'(bus.o_ExecCnt), 32'd3);
        chk("skip_zero", 32'(bus.o_SkipCnt), 32'd0);
`endif

        // Randomized run against the model
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            drive(bit'($urandom_range(0, 3) != 0), 4'($urandom), 2'($urandom), 4'($urandom),
                  bit'($urandom), bit'($urandom), bit'($urandom),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0));
            cyc();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/arm_cond_unit.md
Name: arm_cond_unit

Overview:
Execute-stage conditional-logic controller for the pipelined ARM core. Owns the architectural NZCV flags register and evaluates each Execute-stage instruction's 4-bit condition field against it. Gates PCSrc/RegWrite/MemWrite, updates flags only for executed flag-setting instructions, and registers the gated controls into the Memory stage under hazard-unit stall/flush control.

Parameters:
CNT_W, 32, width of the executed/skipped performance counters (optional feature only)
FLAGS_RST, 4'h0, reset value of {N,Z,C,V}

Ports:
i_CLK  input  1  core clock; all state updates on rising edge
i_RST  input  1  synchronous, active-high reset
i_Stall  input  1  hold Memory-stage register, flags and counters
i_Flush  input  1  squash the Execute-stage instruction (bubble into Memory)
i_Valid_E  input  1  Execute stage holds a real instruction
i_Cond_E  input  4  condition field, ARM encoding 0x0 EQ .. 0xE AL, 0xF NV
i_FlagWrite_E  input  2  [1]=update N,Z; [0]=update C,V
i_ALUFlags_E  input  4  {N,Z,C,V} from the Execute ALU
i_PCSrc_E  input  1  instruction writes PC
i_RegWrite_E  input  1  instruction writes register file
i_MemWrite_E  input  1  instruction writes memory
o_CondEx_E  output  1  condition passed (combinational)
o_PCSrc_E  output  1  gated PCSrc for branch redirect (combinational)
o_PCSrc_M  output  1  registered gated PCSrc
o_RegWrite_M  output  1  registered gated RegWrite
o_MemWrite_M  output  1  registered gated MemWrite
o_Flags  output  4  current architectural {N,Z,C,V}
o_ExecCnt  output  CNT_W  conditional instructions executed (optional feature)
o_SkipCnt  output  CNT_W  conditional instructions skipped (optional feature)

Behaviour:
- Reset (i_RST high at edge): flags <= FLAGS_RST; all _M outputs <= 0; counters <= 0. Reset overrides stall/flush.
- Condition eval uses registered flags only (no same-cycle ALU bypass): EQ Z; NE !Z; HS C; LO !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; NV 0.
- live = i_Valid_E & !i_Flush. o_CondEx_E = live & condpass. o_PCSrc_E = o_CondEx_E & i_PCSrc_E.
- Flag update at edge when !i_Stall & o_CondEx_E: if FlagWrite[1] N,Z <= ALUFlags[3:2]; if FlagWrite[0] C,V <= ALUFlags[1:0]. Halves independent; failed/squashed instructions never modify flags.
- Memory register, 1-cycle latency, when !i_Stall: X_M <= o_CondEx_E & X_E for PCSrc, RegWrite, MemWrite. Flush loads zeros.
- i_Stall high: all state holds, i_Flush ignored that cycle (stall wins; hazard unit re-asserts flush).
- Back-to-back: flag-setter in cycle n, conditional in n+1 sees updated flags.
- Reset mid-stall: reset wins; next cycle state is reset values.

Optional Feature:
ARM_COND_PERF_CNT_EN
- Defined: when !i_Stall & live & i_Cond_E != AL, o_ExecCnt += condpass, o_SkipCnt += !condpass; both saturate at all-ones, never wrap.
- Undefined: counter registers absent; o_ExecCnt/o_SkipCnt tied to 0; ports remain.

Decomposition:
- Package arm_cond_pkg: condition_t enum (EQ..AL, NV=4'hF), flags_t packed struct {N,Z,C,V}, FLAG_N/Z/C/V bit-index constants.
- Sub-module arm_cond_eval: pure combinational condition_t + flags_t -> pass; instantiated once. Top holds flags register, Memory register, counters.

Test Plan:
- Reset then idle -> o_Flags=4'h0, all _M=0, counters 0; EQ with Valid -> o_CondEx_E=0, NE -> 1.
- FlagWrite=2'b11, ALUFlags=4'b0100, AL -> next cycle o_Flags=4'b0100; following EQ+RegWrite -> o_RegWrite_M=1 one cycle later.
- Flags 4'b1000 (N=1,V=0): GE MemWrite -> o_MemWrite_M=0, flags unchanged despite FlagWrite=2'b11; LT -> passes.
- FlagWrite=2'b01, ALUFlags=4'b1111 from flags 0 -> o_Flags=4'b0011 (NZ untouched).
- Stall+Flush with pass BEQ -> _M and flags hold; next cycle Flush only -> _M=0, flags unchanged.
- ARM_COND_PERF_CNT_EN, CNT_W=2: 5 passing EQ -> o_ExecCnt=3 saturated; AL instructions never counted.
